// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the operation encodings seen on the op port and the controller state encodings.
package md_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div         : 1 selects restoring-divide step, 0 selects shift-add multiply step
//   acc_hi, acc_lo : current accumulator (partial product or remainder / quotient+dividend)
//   opnd           : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   nxt_hi, nxt_lo : accumulator after this iteration
module md_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set, then shift the
        // whole {carry, hi, lo} right by one.
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

        // Divide: bring the next dividend bit into the remainder and try a subtract.
        // When it fits, the true difference is below 2^WIDTH, so a WIDTH-bit subtract suffices.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        diff    = shifted[WIDTH-1:0] - opnd;

        if (is_div) begin
            nxt_hi = fits ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], fits};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Works on operand magnitudes one bit per cycle, then fixes signs in a final cycle.
// Ports:
//   clk, reset (async, active-low)
//   start, op, src_a, src_b : request; latched when accepted
//   flush                   : aborts an in-flight operation without writing HI/LO
//   busy, done              : in progress / one-cycle completion pulse
//   hi, lo                  : architectural HI and LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
    logic             is_div, neg_q, neg_r, div_zero;

    // Request decode and operand magnitudes
    logic             is_md, in_div, in_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_md     = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
        in_div    = (op == OpDiv) || (op == OpDivu);
        in_signed = SIGNED_EN && ((op == OpMult) || (op == OpDiv));
        a_neg     = in_signed && src_a[WIDTH-1];
        b_neg     = in_signed && src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
    end

    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    md_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo  = neg_q ? -acc_lo : acc_lo;
        rem  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !flush) begin
                        if (is_md) begin
                            state    <= StRun;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            acc_hi   <= '0;
                            // Multiply shifts the multiplier out of lo; divide shifts the
                            // dividend out of lo while the quotient shifts in.
                            acc_lo   <= in_div ? a_mag : b_mag;
                            opnd     <= in_div ? b_mag : a_mag;
                            a_raw    <= src_a;
                            is_div   <= in_div;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (src_b == '0);
                        end else if (op == OpMthi) begin
                            hi <= src_a;
                        end else if (op == OpMtlo) begin
                            lo <= src_a;
                        end
                    end
                end
                StRun: begin
                    if (flush) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + CW'(1);
                        if (cnt == LastIter) begin
                            state <= StFix;
                        end
                    end
                end
                StFix: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end else if (div_zero) begin
                            // Divide by zero returns the raw dividend, not a sign-fixed one
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit at WIDTH=32, SIGNED_EN=1.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(
        .WIDTH     (32),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge, then scramble the operand inputs.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd7;
        src_a = 32'hA5A5_5A5A;
        src_b = 32'h0000_0000;
    endtask

    // Issue an MD op and follow it to completion: busy for 33 edges, then done with results.
    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int bad_cycle;
        bad_cycle = -1;
        issue(o, a, b);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b required 1", name, busy);
        end
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if ((busy !== 1'b1 || done !== 1'b0) && bad_cycle < 0) bad_cycle = i;
        end
        n_checks++;
        if (bad_cycle >= 0) begin
            n_fail++;
            $display("FAIL %s run: busy/done wrong at cycle %0d, required busy=1 done=0",
                     name, bad_cycle);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s finish: busy=%b done=%b required busy=0 done=1", name, busy, done);
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h",
                     name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        src_a = '0;
        src_b = '0;
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        run_md("mult_neg", OpMult, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done_pulse: done=%b required 0", done);
        end
        run_md("mult_pos", OpMult, 32'h0000_1234, 32'h0001_0000, 32'h0000_0000, 32'h1234_0000);
    endtask

    // Second op starts in the done cycle of the first
    task automatic test_back_to_back;
        run_md("multu", OpMultu, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div_neg", OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_md("divu_big", OpDivu, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC);
    endtask

    task automatic test_div_zero;
        run_md("divu_zero", OpDivu, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_md("div_zero_neg", OpDiv, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9,
               32'hFFFF_FFFF);
    endtask

    task automatic test_mthi_mtlo;
        logic busy_seen;
        issue(OpMthi, 32'h0000_1234, 32'h0);
        busy_seen = busy;
        n_checks++;
        if (hi !== 32'h0000_1234 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: hi=%h done=%b required hi=00001234 done=0", hi, done);
        end
        issue(OpMtlo, 32'h0000_5678, 32'h0);
        busy_seen = busy_seen | busy;
        @(posedge clk);
        #1;
        busy_seen = busy_seen | busy;
        n_checks++;
        if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234 || busy_seen !== 1'b0
            || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: hi=%h lo=%h busy_seen=%b done=%b required 00001234 00005678 0 0",
                     hi, lo, busy_seen, done);
        end
    endtask

    task automatic test_flush_priority;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OpMthi;
        src_a = 32'h0000_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (hi !== 32'h0000_1234 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority: hi=%h busy=%b required hi=00001234 busy=0", hi, busy);
        end
        // Flush alone in idle, then an MD start with flush held is also dropped
        @(negedge clk);
        start = 1'b1;
        op    = OpMult;
        src_a = 32'h3;
        src_b = 32'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
            n_fail++;
            $display("FAIL flush_drop_md: busy=%b hi=%h lo=%h required 0 00001234 00005678",
                     busy, hi, lo);
        end
    endtask

    task automatic test_ignore_start_busy;
        logic done_cnt_ok;
        issue(OpMultu, 32'h0000_0003, 32'h0000_0005);
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                @(negedge clk);
                start = 1'b1;
                op    = OpMthi;
                src_a = 32'h0000_ABCD;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        done_cnt_ok = (done === 1'b1);
        n_checks++;
        if (!done_cnt_ok || hi !== 32'h0 || lo !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL ignore_start_busy: done=%b hi=%h lo=%h required 1 00000000 0000000F",
                     done, hi, lo);
        end
    endtask

    task automatic test_flush;
        int done_seen;
        done_seen = 0;
        issue(OpMult, 32'h0000_0003, 32'h0000_0004);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL flush_abort: busy=%b hi=%h lo=%h required 0 00000000 0000000F",
                     busy, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0 || hi !== 32'h0 || lo !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL flush_quiet: %0d cycles busy/done, hi=%h lo=%h required 0 00000000 0000000F",
                     done_seen, hi, lo);
        end
        run_md("after_flush", OpMultu, 32'h0000_0006, 32'h0000_0007, 32'h0, 32'h0000_002A);
    endtask

    task automatic test_reset_mid_div;
        issue(OpDiv, 32'h0000_0064, 32'h0000_0007);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        run_md("after_reset", OpDivu, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002,
               32'h0000_000E);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_mthi_mtlo();
        test_flush_priority();
        test_ignore_start_busy();
        test_flush();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
